// File: rtl/booth_pkg.sv
// Shared types and constants for the Booth multiplier front-end arbiter.
package booth_pkg;

  // Default watchdog limit, in WAIT cycles
  localparam int unsigned TIMEOUT_DEFAULT = 64;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Width of a requester index; at least one bit so ports never collapse
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester above last_grant, wrapping around.
module rr_arbiter
  import booth_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]              req,
  input  logic [id_width(NUM_REQ)-1:0]    last_grant,
  output logic [NUM_REQ-1:0]              grant_c,
  output logic [id_width(NUM_REQ)-1:0]    index_c
);

  localparam int unsigned IDW = id_width(NUM_REQ);

  logic             found;
  int unsigned      cand;
  logic [IDW-1:0]   cand_idx;

  // Scan offsets 1..NUM_REQ from the last winner; the first active request wins
  always_comb begin
    grant_c  = '0;
    index_c  = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand     = (32'(last_grant) + off) % NUM_REQ;
      cand_idx = IDW'(cand);
      if (!found && req[cand_idx]) begin
        found             = 1'b1;
        grant_c[cand_idx] = 1'b1;
        index_c           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/booth_arbiter.sv
// Shares one Booth multiplier among NUM_REQ requesters with a watchdog abort.
module booth_arbiter
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]        req_a,
  input  logic [NUM_REQ*WIDTH-1:0]        req_b,
  output logic                            mul_start,
  output logic [WIDTH-1:0]                mul_a,
  output logic [WIDTH-1:0]                mul_b,
  input  logic                            mul_done,
  input  logic [2*WIDTH-1:0]              mul_product,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [id_width(NUM_REQ)-1:0]    rsp_id,
  output logic [2*WIDTH-1:0]              rsp_product,
  output logic                            rsp_timeout,
  output logic                            busy
);

  localparam int unsigned IDW = id_width(NUM_REQ);
  localparam int unsigned WDW = $clog2(TIMEOUT) + 1;

  state_t                state;
  state_t                state_next;
  logic [IDW-1:0]        last_grant;
  logic [IDW-1:0]        grant_idx;
  logic [NUM_REQ-1:0]    grant;
  logic [WDW-1:0]        watchdog;
  logic                  accept;
  logic                  wd_expired;
  logic [WIDTH-1:0]      sel_a;
  logic [WIDTH-1:0]      sel_b;

  rr_arbiter #(
    .NUM_REQ    (NUM_REQ)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant_c    (grant),
    .index_c    (grant_idx)
  );

  assign accept     = |(req_valid & req_ready);
  assign wd_expired = (state == ST_WAIT) && (watchdog == WDW'(TIMEOUT - 1));

  // Operand mux for the current round-robin winner
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; mul_done takes priority over watchdog expiry
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept) state_next = ST_START;
      ST_START: state_next = ST_WAIT;
      ST_WAIT:  if (mul_done || wd_expired) state_next = ST_RESP;
      ST_RESP:  if (rsp_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Control outputs decoded from the state register; ready is gated while in reset
  always_comb begin
    req_ready = '0;
    mul_start = 1'b0;
    rsp_valid = 1'b0;
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE:  if (!rst) req_ready = grant;
      ST_START: mul_start = 1'b1;
      ST_RESP:  rsp_valid = 1'b1;
      default:  ;
    endcase
  end

  // Watchdog: cleared on START, counts every WAIT cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      watchdog <= '0;
    end else if (state == ST_START) begin
      watchdog <= '0;
    end else if (state == ST_WAIT) begin
      watchdog <= watchdog + WDW'(1);
    end
  end

  // Operand and id capture on request handshake; held until the next accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a  <= '0;
      mul_b  <= '0;
      rsp_id <= '0;
    end else if (accept) begin
      mul_a  <= sel_a;
      mul_b  <= sel_b;
      rsp_id <= grant_idx;
    end
  end

  // Response capture: product on completion, zero plus timeout flag on abort
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_product <= '0;
      rsp_timeout <= 1'b0;
    end else if (state == ST_WAIT) begin
      if (mul_done) begin
        rsp_product <= mul_product;
        rsp_timeout <= 1'b0;
      end else if (wd_expired) begin
        rsp_product <= '0;
        rsp_timeout <= 1'b1;
      end
    end
  end

  // Round-robin pointer advances only when a response is consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= IDW'(NUM_REQ - 1);
    end else if ((state == ST_RESP) && rsp_ready) begin
      last_grant <= rsp_id;
    end
  end

endmodule

// File: tb/tb_booth_arbiter.sv
// Randomized bench for booth_arbiter with a behavioural round-robin/multiplier model.
module tb_booth_arbiter;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned IDW     = 2;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*WIDTH-1:0]   req_a;
  logic [NUM_REQ*WIDTH-1:0]   req_b;
  logic                       mul_start;
  logic [WIDTH-1:0]           mul_a;
  logic [WIDTH-1:0]           mul_b;
  logic                       mul_done;
  logic [2*WIDTH-1:0]         mul_product;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [IDW-1:0]             rsp_id;
  logic [2*WIDTH-1:0]         rsp_product;
  logic                       rsp_timeout;
  logic                       busy;

  int vectors = 0;
  int errors  = 0;
  int ref_last = NUM_REQ - 1;

  always #5 clk = ~clk;

  booth_arbiter #(
    .WIDTH       (WIDTH),
    .NUM_REQ     (NUM_REQ),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .mul_start   (mul_start),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_done    (mul_done),
    .mul_product (mul_product),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .rsp_timeout (rsp_timeout),
    .busy        (busy)
  );

  // Reference round-robin: first active requester after the last served one
  function automatic int ref_pick(input logic [NUM_REQ-1:0] v);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (v[(ref_last + k) % NUM_REQ]) return (ref_last + k) % NUM_REQ;
    end
    return 0;
  endfunction

  // One full transaction. lat = cycles from mul_start to mul_done (0 = never).
  task automatic do_txn(input logic [NUM_REQ-1:0] v, input logic [31:0] av,
                        input logic [31:0] bv, input int lat, input int hold,
                        output int got_id);
    int exp_id, exp_rc, got;
    logic [NUM_REQ-1:0] exp_rdy;
    logic [WIDTH-1:0] ea, eb;
    logic signed [2*WIDTH-1:0] sa, sb, ep, exp_p;
    logic exp_to;
    bit bad;
    req_valid = v; req_a = av; req_b = bv; rsp_ready = 1'b0; mul_done = 1'b0;
    #1;
    exp_id  = ref_pick(v);
    exp_rdy = 4'b0001 << exp_id;
    ea = av[exp_id*WIDTH +: WIDTH];
    eb = bv[exp_id*WIDTH +: WIDTH];
    sa = $signed(ea); sb = $signed(eb);
    ep = sa * sb;
    exp_to = !(lat >= 1 && lat <= TIMEOUT);
    exp_p  = exp_to ? '0 : ep;
    exp_rc = exp_to ? TIMEOUT + 1 : lat + 1;
    got_id = -1;

    vectors++;
    if (req_ready !== exp_rdy || busy !== 1'b0) begin
      errors++;
      $display("FAIL grant: req_ready=%b busy=%b, expected req_ready=%b busy=0", req_ready, busy, exp_rdy);
    end

    @(posedge clk); @(negedge clk);
    req_valid = NUM_REQ'($urandom); req_a = $urandom; req_b = $urandom;
    #1;
    vectors++;
    if (mul_start !== 1'b1 || mul_a !== ea || mul_b !== eb || rsp_id !== IDW'(exp_id) ||
        req_ready !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start: mul_start=%b a=%h b=%h id=%0d rdy=%b busy=%b, expected 1 %h %h %0d 0000 1",
               mul_start, mul_a, mul_b, rsp_id, req_ready, busy, ea, eb, exp_id);
    end

    got = -1; bad = 0;
    for (int c = 1; c <= TIMEOUT + 5; c++) begin
      @(posedge clk); @(negedge clk);
      req_valid   = NUM_REQ'($urandom);
      mul_done    = (c == lat);
      mul_product = (c == lat) ? ep : 16'($urandom);
      #1;
      if (rsp_valid === 1'b1) begin
        got = c;
        break;
      end
      if (mul_start !== 1'b0 || mul_a !== ea || mul_b !== eb || req_ready !== '0 || busy !== 1'b1) bad = 1;
    end
    mul_done = 1'b0;

    vectors++;
    if (got != exp_rc) begin
      errors++;
      $display("FAIL rsp_latency: rsp_valid at cycle %0d after start, expected %0d", got, exp_rc);
    end
    vectors++;
    if (bad) begin
      errors++;
      $display("FAIL wait_stable: operands/control changed during WAIT, expected a=%h b=%h held", ea, eb);
    end

    vectors++;
    if (rsp_valid !== 1'b1 || rsp_id !== IDW'(exp_id) || rsp_product !== exp_p || rsp_timeout !== exp_to) begin
      errors++;
      $display("FAIL response: valid=%b id=%0d prod=%h to=%b, expected 1 %0d %h %b",
               rsp_valid, rsp_id, rsp_product, rsp_timeout, exp_id, exp_p, exp_to);
    end
    got_id = int'(rsp_id);

    bad = 0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); @(negedge clk);
      req_valid = NUM_REQ'($urandom);
      mul_done  = 1'($urandom);
      mul_product = 16'($urandom);
      #1;
      if (rsp_valid !== 1'b1 || rsp_id !== IDW'(exp_id) || rsp_product !== exp_p ||
          rsp_timeout !== exp_to || req_ready !== '0 || mul_start !== 1'b0 ||
          mul_a !== ea || mul_b !== eb) bad = 1;
    end
    mul_done = 1'b0;
    if (hold > 0) begin
      vectors++;
      if (bad) begin
        errors++;
        $display("FAIL backpressure: response changed or new grant while rsp_ready=0, expected id=%0d prod=%h held",
                 exp_id, exp_p);
      end
    end

    rsp_ready = 1'b1;
    @(posedge clk);
    ref_last = exp_id;
    @(negedge clk);
    rsp_ready = 1'b0; req_valid = '0;
    #1;
    vectors++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL back_to_idle: busy=%b rsp_valid=%b, expected 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; req_a = '0; req_b = '0;
    mul_done = 1'b1; mul_product = 16'hBEEF; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    vectors++;
    if (busy !== 0 || req_ready !== '0 || mul_start !== 0 || rsp_valid !== 0 || mul_a !== '0 ||
        mul_b !== '0 || rsp_id !== '0 || rsp_product !== '0 || rsp_timeout !== 0) begin
      errors++;
      $display("FAIL reset_state: busy=%b rdy=%b start=%b rv=%b a=%h b=%h id=%0d p=%h to=%b, expected all 0",
               busy, req_ready, mul_start, rsp_valid, mul_a, mul_b, rsp_id, rsp_product, rsp_timeout);
    end
    rst = 1'b0; req_valid = '0; mul_done = 1'b0;
    ref_last = NUM_REQ - 1;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int id;
    for (int n = 0; n < 5; n++) begin
      do_txn(4'hF, $urandom, $urandom, 2 + n, 0, id);
      vectors++;
      if (id != exp_order[n]) begin
        errors++;
        $display("FAIL rr_order[%0d]: rsp_id=%0d, expected %0d", n, id, exp_order[n]);
      end
    end
  endtask

  task automatic test_single();
    int id;
    do_txn(4'b0001, 32'h0000_0007, 32'h0000_00FD, 8, 0, id);
    vectors++;
    if (id != 0) begin
      errors++;
      $display("FAIL single_id: rsp_id=%0d, expected 0", id);
    end
  endtask

  task automatic test_timeout();
    int id;
    do_txn(4'b0100, $urandom, $urandom, 0, 0, id);
  endtask

  task automatic test_backpressure();
    int id;
    do_txn(4'b1010, $urandom, $urandom, 5, 5, id);
  endtask

  task automatic test_spurious_done();
    bit bad;
    int id;
    bad = 0;
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      mul_done = 1'b1; mul_product = 16'($urandom);
      @(posedge clk); @(negedge clk); #1;
      if (busy !== 0 || rsp_valid !== 0 || mul_start !== 0) bad = 1;
    end
    mul_done = 1'b0;
    vectors++;
    if (bad) begin
      errors++;
      $display("FAIL spurious_done: busy/rsp_valid/mul_start rose in IDLE, expected all 0");
    end
    // Completion coinciding with watchdog expiry must not flag a timeout
    do_txn(4'b0010, $urandom, $urandom, TIMEOUT, 0, id);
  endtask

  task automatic test_reset_mid();
    bit bad;
    int id;
    req_valid = 4'b0100; req_a = $urandom; req_b = $urandom;
    @(posedge clk); @(negedge clk);
    req_valid = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (busy !== 0 || req_ready !== '0 || mul_start !== 0 || rsp_valid !== 0 || mul_a !== '0 ||
        mul_b !== '0 || rsp_id !== '0 || rsp_product !== '0 || rsp_timeout !== 0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b rdy=%b start=%b rv=%b a=%h b=%h id=%0d p=%h to=%b, expected all 0",
               busy, req_ready, mul_start, rsp_valid, mul_a, mul_b, rsp_id, rsp_product, rsp_timeout);
    end
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    ref_last = NUM_REQ - 1;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      mul_done = 1'($urandom);
      @(posedge clk); @(negedge clk); #1;
      if (rsp_valid !== 0 || busy !== 0) bad = 1;
    end
    mul_done = 1'b0;
    vectors++;
    if (bad) begin
      errors++;
      $display("FAIL reset_no_rsp: response or busy seen after aborted operation, expected none");
    end
    do_txn(4'hF, $urandom, $urandom, 3, 0, id);
    vectors++;
    if (id != 0) begin
      errors++;
      $display("FAIL reset_priority: rsp_id=%0d, expected 0", id);
    end
  endtask

  task automatic test_random();
    int id;
    logic [NUM_REQ-1:0] v;
    for (int n = 0; n < 40; n++) begin
      v = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      do_txn(v, $urandom, $urandom, $urandom_range(0, TIMEOUT + 6), $urandom_range(0, 3), id);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_timeout();
    test_backpressure();
    test_spurious_done();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, expected finish before 2ms");
    $fatal(1);
  end

endmodule
